// File: rtl/alarm_controller_if.sv
// Alarm controller bus: time inputs, set/control pulses and registered status outputs.
// master drives time and controls; slave is the controller itself.
interface alarm_controller_if;
    logic       sec_tick;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_minute;
    logic       arm;
    logic       disarm;
    logic       stop;
    logic       snooze;
    logic       ring;
    logic       armed;
    logic       snoozing;
    logic [1:0] snooze_left;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       set_err;

    modport master (
        output sec_tick, second, minute, hour, set_en, set_hour, set_minute,
               arm, disarm, stop, snooze,
        input  ring, armed, snoozing, snooze_left, alarm_hour, alarm_minute, set_err
    );

    modport slave (
        input  sec_tick, second, minute, hour, set_en, set_hour, set_minute,
               arm, disarm, stop, snooze,
        output ring, armed, snoozing, snooze_left, alarm_hour, alarm_minute, set_err
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock controller: IDLE/ARMED/RINGING/SNOOZE FSM with ring and snooze timers.
// All state registered; outputs follow the registers, no backpressure.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RINGING = 2'd2;
    localparam logic [1:0] S_SNOOZE  = 2'd3;

    localparam logic [5:0] RING_TERM = 6'(RING_SECS);
    localparam logic [8:0] SNZ_TERM  = 9'(SNOOZE_SECS);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [1:0] state_q, state_d;
    logic [5:0] ring_tmr_q, ring_tmr_d;
    logic [8:0] snz_tmr_q, snz_tmr_d;
    logic [1:0] left_q, left_d;
    logic [4:0] ahour_q, ahour_d;
    logic [5:0] amin_q, amin_d;
    logic       set_err_q, set_err_d;

    logic set_ok;
    logic trigger;

    always_comb begin
        set_ok  = bus.set_en && (bus.set_hour <= 5'd23) && (bus.set_minute <= 6'd59);
        // Compared against the stored alarm, so a same-cycle load cannot trigger itself.
        trigger = bus.sec_tick && (bus.hour == ahour_q) && (bus.minute == amin_q)
                  && (bus.second == 6'd0);

        state_d    = state_q;
        ring_tmr_d = ring_tmr_q;
        snz_tmr_d  = snz_tmr_q;
        left_d     = left_q;
        ahour_d    = ahour_q;
        amin_d     = amin_q;
        set_err_d  = bus.set_en && !set_ok;

        if (set_ok) begin
            ahour_d = bus.set_hour;
            amin_d  = bus.set_minute;
        end

        if (bus.disarm) begin
            state_d    = S_IDLE;
            ring_tmr_d = '0;
            snz_tmr_d  = '0;
            left_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (trigger) begin
                        state_d    = S_RINGING;
                        left_d     = SNZ_MAX;
                        ring_tmr_d = '0;
                    end
                end
                S_RINGING: begin
                    if (bus.stop || set_ok) begin
                        state_d    = S_ARMED;
                        ring_tmr_d = '0;
                    end else if (bus.snooze && (left_q != 2'd0)) begin
                        state_d    = S_SNOOZE;
                        left_d     = left_q - 2'd1;
                        snz_tmr_d  = '0;
                        ring_tmr_d = '0;
                    end else if (bus.sec_tick && (ring_tmr_q != RING_TERM)) begin
                        if (ring_tmr_q == RING_TERM - 6'd1) begin
                            state_d    = S_ARMED;
                            ring_tmr_d = '0;
                        end else begin
                            ring_tmr_d = ring_tmr_q + 6'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (bus.stop || set_ok) begin
                        state_d   = S_ARMED;
                        snz_tmr_d = '0;
                    end else if (bus.sec_tick && (snz_tmr_q != SNZ_TERM)) begin
                        if (snz_tmr_q == SNZ_TERM - 9'd1) begin
                            state_d    = S_RINGING;
                            ring_tmr_d = '0;
                            snz_tmr_d  = '0;
                        end else begin
                            snz_tmr_d = snz_tmr_q + 9'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ring_tmr_q <= '0;
            snz_tmr_q  <= '0;
            left_q     <= '0;
            ahour_q    <= 5'd7;
            amin_q     <= 6'd0;
            set_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_tmr_q <= ring_tmr_d;
            snz_tmr_q  <= snz_tmr_d;
            left_q     <= left_d;
            ahour_q    <= ahour_d;
            amin_q     <= amin_d;
            set_err_q  <= set_err_d;
        end
    end

    assign bus.ring         = (state_q == S_RINGING);
    assign bus.armed        = (state_q != S_IDLE);
    assign bus.snoozing     = (state_q == S_SNOOZE);
    assign bus.snooze_left  = left_q;
    assign bus.alarm_hour   = ahour_q;
    assign bus.alarm_minute = amin_q;
    assign bus.set_err      = set_err_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: expected outputs queued at drive time, popped after each edge.
module tb_alarm_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alarm_controller_if bus();

    alarm_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       ring;
        logic       armed;
        logic       snoozing;
        logic [1:0] left;
        logic [4:0] ah;
        logic [5:0] am;
        logic       err;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    int    hh, mm, ss;

    function automatic obs_t mk(input logic r, input logic a, input logic s, input int l,
                                input int h, input int m, input logic e);
        obs_t o;
        o.ring = r; o.armed = a; o.snoozing = s; o.left = 2'(l);
        o.ah = 5'(h); o.am = 6'(m); o.err = e;
        return o;
    endfunction

    task automatic push_exp(input string t, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic compare_one();
        obs_t  o, e;
        string t;
        o = {bus.ring, bus.armed, bus.snoozing, bus.snooze_left,
             bus.alarm_hour, bus.alarm_minute, bus.set_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%h required=queued entry", o);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    task automatic drive_time();
        bus.hour   = 5'(hh);
        bus.minute = 6'(mm);
        bus.second = 6'(ss);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
        drive_time();
    endtask

    task automatic adv_time();
        ss++;
        if (ss == 60) begin ss = 0; mm++; end
        if (mm == 60) begin mm = 0; hh++; end
        if (hh == 24) hh = 0;
    endtask

    task automatic clr_pulses();
        bus.sec_tick = 1'b0; bus.set_en = 1'b0;
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
    endtask

    // One clock edge; tk adds a sec_tick carrying the current (pre-update) time.
    task automatic edge_only(input bit tk);
        if (tk) bus.sec_tick = 1'b1;
        @(posedge clk); #1;
        clr_pulses();
        if (tk) begin adv_time(); drive_time(); end
    endtask

    task automatic step(input string t, input obs_t e, input bit tk);
        push_exp(t, e);
        edge_only(tk);
        compare_one();
    endtask

    task automatic load(input int h, input int m);
        bus.set_en = 1'b1; bus.set_hour = 5'(h); bus.set_minute = 6'(m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_pulses();
        bus.set_hour = '0; bus.set_minute = '0;
        set_time(6, 59, 59);
        reset = 1'b1;
        #12;
        push_exp("reset_vals", mk(0, 0, 0, 0, 7, 0, 0));
        compare_one();
        @(posedge clk); #1;
        reset = 1'b0;

        // Arm and trigger at 07:00:00.
        bus.arm = 1'b1;
        step("arm", mk(0, 1, 0, 0, 7, 0, 0), 0);
        step("tick_065959", mk(0, 1, 0, 0, 7, 0, 0), 1);
        step("trigger_0700", mk(1, 1, 0, 3, 7, 0, 0), 1);

        // Unattended ring times out on the 60th tick.
        for (int i = 0; i < 58; i++) edge_only(1);
        step("ring_tick59", mk(1, 1, 0, 3, 7, 0, 0), 1);
        step("ring_timeout", mk(0, 1, 0, 3, 7, 0, 0), 1);
        step("no_retrigger", mk(0, 1, 0, 3, 7, 0, 0), 1);

        // Load validation.
        load(24, 10);
        step("bad_load_err", mk(0, 1, 0, 3, 7, 0, 1), 0);
        step("err_one_cycle", mk(0, 1, 0, 3, 7, 0, 0), 0);
        load(23, 60);
        step("bad_minute_err", mk(0, 1, 0, 3, 7, 0, 1), 0);
        load(23, 59);
        step("load_2359", mk(0, 1, 0, 3, 23, 59, 0), 0);

        // Snooze rounds.
        load(7, 2);
        step("load_0702", mk(0, 1, 0, 3, 7, 2, 0), 0);
        set_time(7, 1, 59);
        step("tick_070159", mk(0, 1, 0, 3, 7, 2, 0), 1);
        step("trigger_0702", mk(1, 1, 0, 3, 7, 2, 0), 1);
        for (int r = 0; r < 3; r++) begin
            bus.snooze = 1'b1;
            step($sformatf("snooze_%0d", r), mk(0, 1, 1, 2 - r, 7, 2, 0), 0);
            for (int i = 0; i < 298; i++) edge_only(1);
            step($sformatf("snz_tick299_%0d", r), mk(0, 1, 1, 2 - r, 7, 2, 0), 1);
            step($sformatf("rering_%0d", r), mk(1, 1, 0, 2 - r, 7, 2, 0), 1);
        end
        bus.snooze = 1'b1;
        step("snooze_ignored", mk(1, 1, 0, 0, 7, 2, 0), 0);
        step("still_ringing", mk(1, 1, 0, 0, 7, 2, 0), 1);
        bus.stop = 1'b1;
        step("stop_ringing", mk(0, 1, 0, 0, 7, 2, 0), 0);

        // Valid load while ringing returns to ARMED.
        load(12, 35);
        step("load_1235", mk(0, 1, 0, 0, 12, 35, 0), 0);
        set_time(12, 34, 59);
        edge_only(1);
        step("trigger_1235", mk(1, 1, 0, 3, 12, 35, 0), 1);
        load(12, 35);
        step("load_in_ring", mk(0, 1, 0, 3, 12, 35, 0), 0);

        // disarm beats stop.
        set_time(12, 34, 59);
        edge_only(1);
        step("trigger_again", mk(1, 1, 0, 3, 12, 35, 0), 1);
        bus.disarm = 1'b1; bus.stop = 1'b1;
        step("disarm_and_stop", mk(0, 0, 0, 0, 12, 35, 0), 0);

        // Async reset while snoozing.
        bus.arm = 1'b1;
        step("rearm", mk(0, 1, 0, 0, 12, 35, 0), 0);
        set_time(12, 34, 59);
        edge_only(1);
        step("trigger_third", mk(1, 1, 0, 3, 12, 35, 0), 1);
        bus.snooze = 1'b1;
        step("snooze_pre_reset", mk(0, 1, 1, 2, 12, 35, 0), 0);
        #2;
        reset = 1'b1;
        #1;
        push_exp("async_reset", mk(0, 0, 0, 0, 7, 0, 0));
        compare_one();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.arm = 1'b1;
        step("arm_after_reset", mk(0, 1, 0, 0, 7, 0, 0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
